// File: rtl/banco_registros_multiporta.sv
// Multi-port register bank: one write port, two registered read ports with write-first
// bypass, pending-write scoreboard and a one-register-per-cycle clear engine.
module banco_registros_multiporta #(
    parameter int BITS_PALAVRA  = 32,
    parameter int END_REGISTROS = 4,
    parameter int NUM_REGISTROS = 16,
    parameter int ZERO_FIXO     = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     hab_escrita,
    input  logic [END_REGISTROS-1:0] end_escrita,
    input  logic [BITS_PALAVRA-1:0]  dado_escrita,
    input  logic [END_REGISTROS-1:0] end_a,
    input  logic [END_REGISTROS-1:0] end_b,
    output logic [BITS_PALAVRA-1:0]  saida_a,
    output logic [BITS_PALAVRA-1:0]  saida_b,
    input  logic                     reserva,
    input  logic [END_REGISTROS-1:0] end_reserva,
    output logic                     ocupado_a,
    output logic                     ocupado_b,
    input  logic                     limpar,
    output logic                     pronto
);

    typedef enum logic {OCIOSO, LIMPANDO} estado_t;

    estado_t                    estado_q;
    logic [END_REGISTROS-1:0]   contador_q;
    logic                       pronto_q;
    logic [BITS_PALAVRA-1:0]    saida_a_q, saida_a_d;
    logic [BITS_PALAVRA-1:0]    saida_b_q, saida_b_d;

    logic [BITS_PALAVRA-1:0]    registros [NUM_REGISTROS];
    logic [NUM_REGISTROS-1:0]   pendentes;

    logic ocioso;
    logic escrita_ok;
    logic reserva_ok;

    assign ocioso = (estado_q == OCIOSO);

    // Writes and reservations to r0 vanish when r0 is hardwired; this also keeps bypass off for r0.
    assign escrita_ok = hab_escrita & ocioso & ~((ZERO_FIXO != 0) && (end_escrita == '0));
    assign reserva_ok = reserva & ocioso & ~((ZERO_FIXO != 0) && (end_reserva == '0));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            contador_q <= '0;
            pronto_q   <= 1'b1;
        end else if (estado_q == OCIOSO) begin
            if (limpar) begin
                estado_q   <= LIMPANDO;
                contador_q <= '0;
                pronto_q   <= 1'b0;
            end
        end else begin
            contador_q <= contador_q + 1'b1;
            if (contador_q == END_REGISTROS'(NUM_REGISTROS - 1)) begin
                estado_q <= OCIOSO;
                pronto_q <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGISTROS; gi++) begin : g_reg
            logic [BITS_PALAVRA-1:0] valor_q;
            logic                    pend_q;
            logic                    limpa_este;
            logic                    escreve_este;
            logic                    reserva_este;

            assign limpa_este   = ~ocioso & (contador_q == END_REGISTROS'(gi));
            assign escreve_este = escrita_ok & (end_escrita == END_REGISTROS'(gi));
            assign reserva_este = reserva_ok & (end_reserva == END_REGISTROS'(gi));

            // A reservation landing with the write means a newer load is outstanding.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    valor_q <= '0;
                    pend_q  <= 1'b0;
                end else if (limpa_este) begin
                    valor_q <= '0;
                    pend_q  <= 1'b0;
                end else begin
                    if (escreve_este) begin
                        valor_q <= dado_escrita;
                    end
                    if (reserva_este) begin
                        pend_q <= 1'b1;
                    end else if (escreve_este) begin
                        pend_q <= 1'b0;
                    end
                end
            end

            assign registros[gi] = valor_q;
            assign pendentes[gi] = pend_q;
        end
    endgenerate

    always_comb begin
        saida_a_d = registros[end_a];
        saida_b_d = registros[end_b];
        if (escrita_ok && (end_escrita == end_a)) begin
            saida_a_d = dado_escrita;
        end
        if (escrita_ok && (end_escrita == end_b)) begin
            saida_b_d = dado_escrita;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            saida_a_q <= '0;
            saida_b_q <= '0;
        end else begin
            saida_a_q <= saida_a_d;
            saida_b_q <= saida_b_d;
        end
    end

    // An operand being written back this cycle is no longer a hazard.
    assign ocupado_a = pendentes[end_a] & ~(hab_escrita & ocioso & (end_escrita == end_a));
    assign ocupado_b = pendentes[end_b] & ~(hab_escrita & ocioso & (end_escrita == end_b));

    assign saida_a = saida_a_q;
    assign saida_b = saida_b_q;
    assign pronto  = pronto_q;

endmodule

// File: tb/tb_banco_registros_multiporta.sv
// Directed scoreboard bench for banco_registros_multiporta: the driver queues hand-computed
// expectations per cycle and an independent monitor compares them against the DUT.
module tb_banco_registros_multiporta;

    logic        clock;
    logic        reset;
    logic        hab_escrita;
    logic [3:0]  end_escrita;
    logic [31:0] dado_escrita;
    logic [3:0]  end_a;
    logic [3:0]  end_b;
    logic [31:0] saida_a;
    logic [31:0] saida_b;
    logic        reserva;
    logic [3:0]  end_reserva;
    logic        ocupado_a;
    logic        ocupado_b;
    logic        limpar;
    logic        pronto;

    banco_registros_multiporta #(
        .BITS_PALAVRA (32),
        .END_REGISTROS(4),
        .NUM_REGISTROS(16),
        .ZERO_FIXO    (1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .hab_escrita (hab_escrita),
        .end_escrita (end_escrita),
        .dado_escrita(dado_escrita),
        .end_a       (end_a),
        .end_b       (end_b),
        .saida_a     (saida_a),
        .saida_b     (saida_b),
        .reserva     (reserva),
        .end_reserva (end_reserva),
        .ocupado_a   (ocupado_a),
        .ocupado_b   (ocupado_b),
        .limpar      (limpar),
        .pronto      (pronto)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        bit          c_oc;
        bit          oa;
        bit          ob;
        bit          c_pre;
        bit          pre_p;
        bit          c_out;
        logic [31:0] a;
        logic [31:0] b;
        bit          p;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input string n, input bit c_oc, input bit oa, input bit ob,
                                input bit c_pre, input bit pre_p, input bit c_out,
                                input logic [31:0] a, input logic [31:0] b, input bit p);
        exp_t e;
        e.name = n; e.c_oc = c_oc; e.oa = oa; e.ob = ob;
        e.c_pre = c_pre; e.pre_p = pre_p;
        e.c_out = c_out; e.a = a; e.b = b; e.p = p;
        return e;
    endfunction

    function automatic logic [31:0] val(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h111;
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    // Inputs change on the falling edge; the matching expectation is queued at the same time.
    task automatic cyc(input logic r, input logic we, input logic [3:0] ew, input logic [31:0] wd,
                       input logic [3:0] ea, input logic [3:0] eb, input logic rs,
                       input logic [3:0] er, input logic lm, input exp_t e);
        @(negedge clock);
        reset = r; hab_escrita = we; end_escrita = ew; dado_escrita = wd;
        end_a = ea; end_b = eb; reserva = rs; end_reserva = er; limpar = lm;
        sb.push_back(e);
        $display("cycle %-14s rst=%0b we=%0b ew=%0d wd=%h ea=%0d eb=%0d res=%0b er=%0d lim=%0b",
                 e.name, r, we, ew, wd, ea, eb, rs, er, lm);
    endtask

    // Monitor: combinational outputs just before the rising edge, registered ones just after.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #4;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.c_pre) chk({e.name, "/pronto_pre"}, 32'(pronto), 32'(e.pre_p));
                if (e.c_oc) begin
                    chk({e.name, "/ocupado_a"}, 32'(ocupado_a), 32'(e.oa));
                    chk({e.name, "/ocupado_b"}, 32'(ocupado_b), 32'(e.ob));
                end
                if (e.c_out) begin
                    @(posedge clock);
                    #1;
                    chk({e.name, "/saida_a"}, saida_a, e.a);
                    chk({e.name, "/saida_b"}, saida_b, e.b);
                    chk({e.name, "/pronto"}, 32'(pronto), 32'(e.p));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; hab_escrita = 1'b0; end_escrita = '0; dado_escrita = '0;
        end_a = '0; end_b = '0; reserva = 1'b0; end_reserva = '0; limpar = 1'b0;

        // Reset and first reads
        cyc(0, 0, 0, 0, 3, 15, 0, 0, 0, mk("reset", 1, 0, 0, 1, 1, 1, 0, 0, 1));
        cyc(1, 0, 0, 0, 3, 15, 0, 0, 0, mk("rst_read", 1, 0, 0, 1, 1, 1, 0, 0, 1));

        // Write, read back and bypass
        cyc(1, 1, 5, 32'hDEADBEEF, 3, 15, 0, 0, 0, mk("wr_r5", 1, 0, 0, 0, 0, 1, 0, 0, 1));
        cyc(1, 1, 7, 32'h12345678, 5, 7, 0, 0, 0,
            mk("bypass_b", 1, 0, 0, 0, 0, 1, 32'hDEADBEEF, 32'h12345678, 1));
        cyc(1, 0, 0, 0, 7, 5, 0, 0, 0,
            mk("rd_r7_r5", 1, 0, 0, 0, 0, 1, 32'h12345678, 32'hDEADBEEF, 1));

        // Hardwired zero register
        cyc(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, mk("zero_wr", 1, 0, 0, 0, 0, 1, 0, 0, 1));
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, mk("zero_res", 1, 0, 0, 0, 0, 1, 0, 0, 1));
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, mk("zero_after", 1, 0, 0, 0, 0, 1, 0, 0, 1));

        // Scoreboard
        cyc(1, 0, 0, 0, 9, 5, 1, 9, 0, mk("res_r9", 1, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 1));
        cyc(1, 0, 0, 0, 9, 9, 0, 0, 0, mk("busy_r9", 1, 1, 1, 0, 0, 1, 0, 0, 1));
        cyc(1, 1, 9, 32'hA5A5A5A5, 9, 3, 0, 0, 0,
            mk("wb_r9", 1, 0, 0, 0, 0, 1, 32'hA5A5A5A5, 0, 1));
        cyc(1, 0, 0, 0, 9, 3, 0, 0, 0, mk("free_r9", 1, 0, 0, 0, 0, 1, 32'hA5A5A5A5, 0, 1));
        cyc(1, 1, 9, 32'h5A5A5A5A, 9, 3, 1, 9, 0,
            mk("res_wr_r9", 1, 0, 0, 0, 0, 1, 32'h5A5A5A5A, 0, 1));
        cyc(1, 0, 0, 0, 9, 9, 0, 0, 0,
            mk("res_wins", 1, 1, 1, 0, 0, 1, 32'h5A5A5A5A, 32'h5A5A5A5A, 1));

        // Fill r1..r15, checked through port A bypass
        for (int i = 1; i < 16; i++) begin
            cyc(1, 1, 4'(i), val(i), 4'(i), 0, 0, 0, 0,
                mk($sformatf("fill_r%0d", i), 0, 0, 0, 0, 0, 1, val(i), 0, 1));
        end
        cyc(1, 0, 0, 0, 4, 0, 1, 4, 0, mk("res_r4", 1, 0, 0, 0, 0, 1, val(4), 0, 1));
        cyc(1, 0, 0, 0, 15, 1, 0, 0, 0, mk("rd_r15_r1", 1, 0, 0, 1, 1, 1, val(15), val(1), 1));

        // Sequenced clear: 16 cycles with pronto low, writes/reserves/limpar ignored
        cyc(1, 0, 0, 0, 2, 4, 0, 0, 1, mk("clr_start", 1, 0, 1, 1, 1, 1, val(2), val(4), 0));
        for (int c = 0; c < 16; c++) begin
            cyc(1, (c == 5), 2, 32'hFFFFFFFF, 4'(c), (c == 5) ? 4'd2 : ((c == 0) ? 4'd0 : 4'(c - 1)),
                (c == 6), 1, (c == 7),
                mk($sformatf("clr_c%0d", c), 1, (c == 4), 0, 1, 0, 1,
                   (c == 0) ? 32'h0 : val(c), 0, (c == 15)));
        end
        for (int i = 0; i < 16; i += 2) begin
            cyc(1, 0, 0, 0, 4'(i), 4'(i + 1), 0, 0, 0,
                mk($sformatf("post_clr_%0d", i), 1, 0, 0, 1, 1, 1, 0, 0, 1));
        end

        // Reset in the middle of a clear
        cyc(1, 1, 12, 32'hCAFEF00D, 0, 0, 0, 0, 0, mk("wr_r12", 0, 0, 0, 1, 1, 1, 0, 0, 1));
        cyc(1, 1, 8, 32'h0BADBEEF, 0, 0, 0, 0, 0, mk("wr_r8", 0, 0, 0, 1, 1, 1, 0, 0, 1));
        cyc(1, 0, 0, 0, 12, 8, 0, 0, 1,
            mk("clr2_start", 0, 0, 0, 1, 1, 1, 32'hCAFEF00D, 32'h0BADBEEF, 0));
        for (int c = 0; c < 6; c++) begin
            cyc(1, 0, 0, 0, 12, 8, 0, 0, 0,
                mk($sformatf("clr2_c%0d", c), 0, 0, 0, 1, 0, 1, 32'hCAFEF00D, 32'h0BADBEEF, 0));
        end
        cyc(0, 0, 0, 0, 12, 8, 0, 0, 0, mk("mid_reset", 1, 0, 0, 1, 1, 1, 0, 0, 1));
        cyc(1, 1, 8, 32'h00000077, 12, 8, 0, 0, 0, mk("after_rst_wr", 1, 0, 0, 1, 1, 1, 0, 32'h77, 1));
        cyc(1, 0, 0, 0, 8, 12, 0, 0, 0, mk("after_rst_rd", 1, 0, 0, 1, 1, 1, 32'h77, 0, 1));

        repeat (4) @(negedge clock);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
